// File: rtl/axi_ram_fill_pkg.sv
// Shared types and constants for the AXI4 fill engine: FSM encoding, AXI codes and
// the helper that limits a burst to the current 4 KB page.
package axi_ram_fill_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } fill_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BoundaryBytes = 4096;

  // Words left before the next 4 KB boundary, or before address wrap for narrow buses.
  function automatic int unsigned boundary_words(input logic [31:0] addr,
                                                 input int unsigned addr_width,
                                                 input int unsigned size_log2);
    logic [31:0] region;
    logic [31:0] offset;
    region = (addr_width >= 12) ? 32'(BoundaryBytes) : (32'd1 << addr_width);
    offset = addr & (region - 32'd1);
    return (region - offset) >> size_log2;
  endfunction

endpackage

// File: rtl/axi_ram_fill_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the fill engine and its slave.
interface axi_ram_fill_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_ram_fill.sv
// AXI4 fill engine: writes a constant or incrementing pattern over a word-aligned region
// as INCR bursts capped by MAX_BURST_LEN and 4 KB pages, one burst outstanding at a time.
module axi_ram_fill
  import axi_ram_fill_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic [DATA_WIDTH-1:0]  cmd_pattern,
  input  logic                   cmd_incr,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  axi_ram_fill_if.master         m_axi
);

  localparam int unsigned SizeLog2 = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0]  addr,
                                            input logic [COUNT_WIDTH-1:0] rem);
    int unsigned beats;
    int unsigned limit;
    beats = 32'(rem);
    if (beats > MAX_BURST_LEN) beats = MAX_BURST_LEN;
    limit = boundary_words(32'(addr), ADDR_WIDTH, SizeLog2);
    if (beats > limit) beats = limit;
    return beats[8:0];
  endfunction

  fill_state_e            state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] rem_q;
  logic [8:0]             beats_q;
  logic [8:0]             beat_cnt_q;
  logic                   incr_q;
  logic                   err_acc_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [ADDR_WIDTH-1:0]  awaddr_q;
  logic [7:0]             awlen_q;
  logic                   awvalid_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   wlast_q;
  logic                   wvalid_q;
  logic                   bready_q;

  logic [ADDR_WIDTH-1:0]  start_addr;
  logic [8:0]             start_beats;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [COUNT_WIDTH-1:0] next_rem;
  logic [8:0]             next_beats;
  logic                   burst_err;

  always_comb begin
    start_addr  = cmd_addr & AlignMask;
    start_beats = calc_beats(start_addr, cmd_count);
    next_addr   = addr_q + ADDR_WIDTH'(32'(beats_q) << SizeLog2);
    next_rem    = rem_q - COUNT_WIDTH'(beats_q);
    next_beats  = calc_beats(next_addr, next_rem);
    burst_err   = (m_axi.bresp != RESP_OKAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      incr_q     <= 1'b0;
      err_acc_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (cmd_count == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= StAddr;
              busy_q    <= 1'b1;
              addr_q    <= start_addr;
              rem_q     <= cmd_count;
              beats_q   <= start_beats;
              awaddr_q  <= start_addr;
              awlen_q   <= 8'(start_beats - 9'd1);
              awvalid_q <= 1'b1;
              wdata_q   <= cmd_pattern;
              incr_q    <= cmd_incr;
              err_acc_q <= 1'b0;
            end
          end
        end
        StAddr: begin
          if (m_axi.awready) begin
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b1;
            wlast_q    <= (beats_q == 9'd1);
            beat_cnt_q <= beats_q;
            state_q    <= StData;
          end
        end
        StData: begin
          if (m_axi.wready) begin
            // Running word index from command start lives in wdata itself.
            wdata_q    <= wdata_q + DATA_WIDTH'(incr_q);
            beat_cnt_q <= beat_cnt_q - 9'd1;
            wlast_q    <= (beat_cnt_q == 9'd2);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StResp;
            end
          end
        end
        StResp: begin
          if (m_axi.bvalid) begin
            bready_q  <= 1'b0;
            addr_q    <= next_addr;
            rem_q     <= next_rem;
            err_acc_q <= err_acc_q | burst_err;
            if (next_rem != '0) begin
              beats_q   <= next_beats;
              awaddr_q  <= next_addr;
              awlen_q   <= 8'(next_beats - 9'd1);
              awvalid_q <= 1'b1;
              state_q   <= StAddr;
            end else begin
              done_q  <= 1'b1;
              error_q <= err_acc_q | burst_err;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = 3'(SizeLog2);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = '0;
  assign m_axi.awprot  = '0;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

  logic unused_bid;
  assign unused_bid = ^m_axi.bid;

endmodule
